// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module sync_fifo_ext #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter bit          FWFT       = 1'b0,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  flush,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;
    logic                  ovf_set, udf_set;

    // Explicit wrap so non-power-of-2 depths index correctly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        rd_acc = read_en && !empty;
        wr_acc = write_en && (!full || rd_acc);
        ovf_set = !flush && write_en && !wr_acc;
        udf_set = !flush && read_en && empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
            if (rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CW'(1);
            end
        end

        // A new error in the same cycle as clear_err keeps the flag set.
        overflow_d  = (overflow_q && !clear_err) || ovf_set;
        underflow_d = (underflow_q && !clear_err) || udf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && wr_acc) mem[wr_ptr_q] <= data_in;
    end

    if (FWFT) begin : g_fwft
        assign data_out = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (!flush && rd_acc) begin
                dout_q <= mem[rd_ptr_q];
            end
        end
        assign data_out = dout_q;
    end

    always_comb begin
        count        = count_q;
        empty        = (count_q == '0);
        full         = (count_q == CW'(DEPTH));
        almost_full  = (count_q >= CW'(AF_THRESH));
        almost_empty = (count_q <= CW'(AE_THRESH));
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: vector table plus data scoreboard on a depth-5 FIFO,
// hand sequences for first-word-fall-through and threshold flags.
module tb_sync_fifo_ext;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Instance A: DEPTH=5, standard read, default thresholds (AF=3, AE=2)
    logic        a_rst, a_we, a_re, a_fl, a_ce;
    logic [15:0] a_din, a_dout;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0]  a_count;

    sync_fifo_ext #(.DEPTH(5), .DATA_WIDTH(16), .FWFT(1'b0)) u_a (
        .clk(clk), .rst(a_rst), .write_en(a_we), .read_en(a_re), .data_in(a_din),
        .flush(a_fl), .clear_err(a_ce), .data_out(a_dout), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count), .overflow(a_ovf),
        .underflow(a_udf)
    );

    // Instance B: DEPTH=4, first-word-fall-through
    logic        b_rst, b_we, b_re;
    logic [15:0] b_din, b_dout;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0]  b_count;

    sync_fifo_ext #(.DEPTH(4), .DATA_WIDTH(16), .FWFT(1'b1)) u_b (
        .clk(clk), .rst(b_rst), .write_en(b_we), .read_en(b_re), .data_in(b_din),
        .flush(1'b0), .clear_err(1'b0), .data_out(b_dout), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count), .overflow(b_ovf),
        .underflow(b_udf)
    );

    // Instance C: DEPTH=8, AF=6, AE=2
    logic        c_we, c_re;
    logic [15:0] c_din, c_dout;
    logic        c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
    logic [3:0]  c_count;

    sync_fifo_ext #(.DEPTH(8), .DATA_WIDTH(16), .FWFT(1'b0), .AF_THRESH(6), .AE_THRESH(2)) u_c (
        .clk(clk), .rst(b_rst), .write_en(c_we), .read_en(c_re), .data_in(c_din),
        .flush(1'b0), .clear_err(1'b0), .data_out(c_dout), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .count(c_count), .overflow(c_ovf),
        .underflow(c_udf)
    );

    typedef struct {
        logic        rst, we, re, fl, ce;
        logic [15:0] din;
        int          cnt;
        logic        full, empty, ovf, udf;
    } vec_t;

    function automatic vec_t mk(logic rst, logic we, logic re, logic fl, logic ce,
                                logic [15:0] din, int cnt, logic full, logic empty,
                                logic ovf, logic udf);
        vec_t v;
        v.rst = rst; v.we = we; v.re = re; v.fl = fl; v.ce = ce; v.din = din;
        v.cnt = cnt; v.full = full; v.empty = empty; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    vec_t        vecs[$];
    logic [15:0] sb[$];
    logic [15:0] exp_dout;

    initial begin
        a_rst = 1'b1; a_we = 1'b0; a_re = 1'b0; a_fl = 1'b0; a_ce = 1'b0; a_din = '0;
        b_rst = 1'b1; b_we = 1'b0; b_re = 1'b0; b_din = '0;
        c_we = 1'b0; c_re = 1'b0; c_din = '0;
        exp_dout = '0;

        //            rst we re fl ce din      cnt full empty ovf udf
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0001, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0002, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0003, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0004, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0005, 5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0006, 5, 1, 0, 1, 0)); // dropped
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 4, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 3, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0011, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0012, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0013, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0014, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0015, 5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'hAAAA, 5, 1, 0, 0, 0)); // full, both accepted
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'hBEEF, 1, 0, 0, 0, 1)); // empty, write only
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h2001, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h2002, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h2003, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 16'h3333, 0, 0, 1, 0, 0)); // flush wins
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h4444, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h5555, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h6666, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 16'h7777, 0, 0, 1, 0, 0)); // rst mid-burst
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 0, 0, 1, 0, 1)); // set beats clear
        vecs.push_back(mk(0, 0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset data_out", 32'(a_dout), 32'h0);
        chk("reset count", 32'(a_count), 32'd0);
        chk("reset empty", 32'(a_empty), 32'd1);
        chk("reset full", 32'(a_full), 32'd0);
        chk("reset almost_empty", 32'(a_ae), 32'd1);
        chk("reset almost_full", 32'(a_af), 32'd0);
        chk("reset overflow", 32'(a_ovf), 32'd0);
        chk("reset underflow", 32'(a_udf), 32'd0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            a_rst = vecs[i].rst; a_we = vecs[i].we; a_re = vecs[i].re;
            a_fl = vecs[i].fl; a_ce = vecs[i].ce; a_din = vecs[i].din;
            @(posedge clk);
            if (vecs[i].rst) begin
                sb.delete();
                exp_dout = '0;
            end else if (vecs[i].fl) begin
                sb.delete();
            end else begin
                automatic bit rd = vecs[i].re && (sb.size() != 0);
                automatic bit wr = vecs[i].we && (sb.size() < 5 || rd);
                if (rd) exp_dout = sb.pop_front();
                if (wr) sb.push_back(vecs[i].din);
            end
            @(negedge clk);
            chk($sformatf("v%0d count", i), 32'(a_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d full", i), 32'(a_full), 32'(vecs[i].full));
            chk($sformatf("v%0d empty", i), 32'(a_empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d almost_full", i), 32'(a_af), 32'(vecs[i].cnt >= 3));
            chk($sformatf("v%0d almost_empty", i), 32'(a_ae), 32'(vecs[i].cnt <= 2));
            chk($sformatf("v%0d overflow", i), 32'(a_ovf), 32'(vecs[i].ovf));
            chk($sformatf("v%0d underflow", i), 32'(a_udf), 32'(vecs[i].udf));
            chk($sformatf("v%0d data_out", i), 32'(a_dout), 32'(exp_dout));
        end
        a_rst = 1'b0; a_we = 1'b0; a_re = 1'b0; a_fl = 1'b0; a_ce = 1'b0;

        // First-word-fall-through
        chk("fwft idle data_out", 32'(b_dout), 32'h0);
        chk("fwft idle empty", 32'(b_empty), 32'd1);
        b_we = 1'b1; b_din = 16'h1234;
        tick();
        b_we = 1'b0;
        chk("fwft fall-through data", 32'(b_dout), 32'h1234);
        chk("fwft fall-through empty", 32'(b_empty), 32'd0);
        b_we = 1'b1; b_din = 16'h5678;
        tick();
        b_we = 1'b0;
        chk("fwft head held", 32'(b_dout), 32'h1234);
        chk("fwft count 2", 32'(b_count), 32'd2);
        b_re = 1'b1;
        tick();
        chk("fwft pop1 data", 32'(b_dout), 32'h5678);
        tick();
        b_re = 1'b0;
        chk("fwft pop2 data", 32'(b_dout), 32'h0);
        chk("fwft pop2 empty", 32'(b_empty), 32'd1);
        b_we = 1'b1; b_re = 1'b1; b_din = 16'h9ABC;
        tick();
        b_we = 1'b0; b_re = 1'b0;
        chk("fwft empty rw data", 32'(b_dout), 32'h9ABC);
        chk("fwft empty rw count", 32'(b_count), 32'd1);
        chk("fwft empty rw underflow", 32'(b_udf), 32'd1);

        // Threshold flags, DEPTH=8 AF=6 AE=2
        for (int i = 1; i <= 8; i++) begin
            c_we = 1'b1; c_din = 16'(i);
            tick();
            chk($sformatf("fill%0d count", i), 32'(c_count), 32'(i));
            chk($sformatf("fill%0d almost_empty", i), 32'(c_ae), 32'(i <= 2));
            chk($sformatf("fill%0d almost_full", i), 32'(c_af), 32'(i >= 6));
            chk($sformatf("fill%0d full", i), 32'(c_full), 32'(i == 8));
        end
        c_we = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            c_re = 1'b1;
            tick();
            chk($sformatf("drain%0d count", i), 32'(c_count), 32'(i));
            chk($sformatf("drain%0d almost_empty", i), 32'(c_ae), 32'(i <= 2));
            chk($sformatf("drain%0d almost_full", i), 32'(c_af), 32'(i >= 6));
            chk($sformatf("drain%0d empty", i), 32'(c_empty), 32'(i == 0));
            chk($sformatf("drain%0d data", i), 32'(c_dout), 32'(8 - i));
        end
        c_re = 1'b0;
        chk("c no overflow", 32'(c_ovf), 32'd0);
        chk("c no underflow", 32'(c_udf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
